mgmt_drp_bridge: RTL and testbench
==================================

// Module: mgmt_drp_bridge
// PURPOSE
// Parametrised successor to the fixed two-lane DRP register block in the management domain. Maps NUM_LANES
// SERDES DRP ports into the 16-bit-address / 8-bit-data management register space (QSPI bridge side).
// Each lane has its own register window, staging registers and IDLE/BUSY controller.
// New vs. the fixed block: per-lane staging, DRP timeout with abort, sticky error flags, busy-write rejection.
// PARAMETERS
// NUM_LANES    4        number of DRP ports, 1..16
// BASE_ADDR    16'h0080 management address of lane 0 window
// LANE_STRIDE  16'h0020 address spacing between lane windows, power of two, >= 16
// TIMEOUT      1023     cycles from drp_en to abort if drp_done never arrives, 1..65535
// PORTS
// clk          in   1            management core clock; all logic in this domain
// rst          in   1            synchronous active-high reset
// rd_en        in   1            register read strobe
// rd_addr      in   16           read address
// rd_valid     out  1            read data valid, one-cycle pulse
// rd_data      out  8            read data
// wr_en        in   1            register write strobe
// wr_addr      in   16           write address
// wr_data      in   8            write data
// drp_en       out  NUM_LANES    per-lane DRP strobe, one-cycle pulse
// drp_we       out  NUM_LANES    per-lane DRP write enable, valid with drp_en
// drp_addr     out  9*NUM_LANES  per-lane DRP address, lane i at [9i+:9]
// drp_wdata    out  16*NUM_LANES per-lane DRP write data, lane i at [16i+:16]
// drp_rdata    in   16*NUM_LANES per-lane DRP read data, sampled when drp_done is high
// drp_done     in   NUM_LANES    per-lane DRP completion pulse
// rx_rstdone   in   NUM_LANES    per-lane rx reset done (already synchronised), status only
// BEHAVIOUR
// Reset:
//   - rd_valid=0, rd_data=0, drp_en=0, drp_we=0, drp_addr=0, drp_wdata=0.
//   - All lanes IDLE; RD=0; flags=0; timeout counters=0.
// Lane decode:
//   - lane=(addr-BASE_ADDR)/LANE_STRIDE; off=addr[3:0].
//   - Hit only if addr>=BASE_ADDR, lane<NUM_LANES, and off is a defined register.
// Per-lane registers (off):
//   - 4/5: WD lo/hi, R/W.
//   - 6: AD lo, R/W.
//   - 7: AD hi. bit7=we, bit0=addr[8]. Writing it launches the DRP op.
//   - 8/9: RD lo/hi, RO.
//   - A: STAT, RO. {4'b0, overrun, timeout, rstdone, busy}.
//   - B: CTRL, WO. bit0=1 clears overrun and timeout.
// Reads:
//   - rd_valid and rd_data are registered exactly 1 cycle after rd_en. No side effects.
//   - Unmapped address or WO register returns 8'h00 with rd_valid still pulsed.
// Writes:
//   - Take effect the cycle after wr_en.
//   - Writes to unmapped addresses or RO registers are ignored.
// Lane FSM, IDLE -> BUSY:
//   - Trigger: write to AD hi while IDLE.
//   - Next cycle: drp_en[i]=1 for 1 cycle, drp_we/addr/wdata driven from staging. Counter loads 0.
// Lane FSM, BUSY -> IDLE on done:
//   - drp_done[i]: RD<=drp_rdata[i] (RD unchanged if we=1).
// Lane FSM, BUSY -> IDLE on timeout:
//   - Counter reaches TIMEOUT: RD<=16'hFFFF, timeout flag set.
// Boundary rules:
//   - drp_done and timeout in the same cycle: done wins, no timeout flag.
//   - AD hi write while BUSY: no drp_en, staging for AD hi not updated, overrun flag set.
//   - WD/AD lo writes while BUSY update staging only. drp_* outputs stay stable until next launch.
//   - drp_done while IDLE (late after timeout, or after reset): ignored, RD unchanged.
//   - CTRL clear in the same cycle as a flag-set event: set wins.
//   - Lanes are fully independent. Simultaneous ops and completions on different lanes are allowed.
//   - rst mid-op: lane to IDLE immediately, no drp_en issued afterwards.
//   - busy in STAT reads 1 from the cycle after the launching write through the cycle of done/timeout.
// STRUCTURE
// Package DRPBridgePkg:
//   - drp_lane_state_t enum {DRP_IDLE, DRP_BUSY}.
//   - Offset constants DRP_REG_WD/WD_1/AD/AD_1/RD/RD_1/STAT/CTRL.
// Sub-module drp_lane_ctl:
//   - One instance per lane, generate loop.
//   - Contains staging registers, FSM, timeout counter, RD and flags.
//   - Takes decoded per-lane write strobes; exposes RD/STAT for the read mux.
// Top level: address decode, write strobe fan-out, registered read mux.
// TESTING
// 1. Lane 2 read: wr 0x00C6=0x34, 0x00C7=0x01; drp_done[2] with rdata 0xBEEF after 5 cycles
//    -> drp_en[2] pulse with addr=0x134, we=0; STAT busy 1 then 0; 0x00C8/0x00C9 read 0xEF/0xBE.
// 2. Lane 0 write: WD=0xA55A, AD_1=0x80
//    -> drp_en[0] with we=1, wdata=0xA55A, addr=0x000; RD unchanged after done.
// 3. No drp_done on lane 1, TIMEOUT=1023
//    -> busy clears exactly 1023 cycles after drp_en; STAT=0x04|rstdone; RD=0xFFFF.
//    -> Late done ignored; CTRL=0x01 clears flag.
// 4. AD_1 rewrite on lane 3 while BUSY
//    -> no second drp_en; overrun set.
//    -> Same-cycle done+timeout on lane 3 -> RD captured, no timeout flag.
// 5. Concurrent ops on lanes 0 and 3; rst asserted mid-op on lane 0
//    -> lane 0 IDLE, flags 0; lane 3 also reset.
//    -> Read of 0x0180 (lane 8, out of range with NUM_LANES=4) -> rd_valid, data 0x00.

Source files
------------

// File: rtl/mgmt_drp_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : DRPBridgePkg (package)
// Description : Shared types and register offsets for the management-domain
//               DRP bridge. Holds the per-lane FSM state type, the register
//               offsets within a lane window and the offset qualifiers used
//               by the address decoder.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package DRPBridgePkg;

    typedef enum logic [0:0] {
        DRP_IDLE = 1'b0,
        DRP_BUSY = 1'b1
    } drp_lane_state_t;

    // Register offsets within a lane window (address bits [3:0])
    localparam logic [3:0] DRP_REG_WD   = 4'h4;
    localparam logic [3:0] DRP_REG_WD_1 = 4'h5;
    localparam logic [3:0] DRP_REG_AD   = 4'h6;
    localparam logic [3:0] DRP_REG_AD_1 = 4'h7;
    localparam logic [3:0] DRP_REG_RD   = 4'h8;
    localparam logic [3:0] DRP_REG_RD_1 = 4'h9;
    localparam logic [3:0] DRP_REG_STAT = 4'hA;
    localparam logic [3:0] DRP_REG_CTRL = 4'hB;

    // Readable offsets: WD, AD, RD, STAT (CTRL is write-only)
    function automatic logic drp_off_readable(input logic [3:0] off);
        return (off >= DRP_REG_WD) && (off <= DRP_REG_STAT);
    endfunction

    // Writable offsets: WD, AD and CTRL (RD and STAT are read-only)
    function automatic logic drp_off_writable(input logic [3:0] off);
        return ((off >= DRP_REG_WD) && (off <= DRP_REG_AD_1)) || (off == DRP_REG_CTRL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mgmt_drp_bridge_lane_ctl.sv
`default_nettype none
// ============================================================================
// Module      : drp_lane_ctl
// Description : One DRP lane: WD/AD staging registers, IDLE/BUSY controller,
//               timeout counter, RD result register and sticky flags.
//               Ports:
//                 clk, rst          - management clock, sync active-high reset
//                 i_wr_*            - decoded per-register write strobes
//                 i_wr_data         - write byte
//                 i_drp_rdata/done  - DRP read data and completion pulse
//                 i_rx_rstdone      - rx reset done status bit
//                 o_drp_*           - registered DRP request outputs
//                 o_wd/o_ad/o_rd    - register contents for the read mux
//                 o_stat            - {4'b0, overrun, timeout, rstdone, busy}
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module drp_lane_ctl
    import DRPBridgePkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wr_wd_lo,
    input  logic        i_wr_wd_hi,
    input  logic        i_wr_ad_lo,
    input  logic        i_wr_ad_hi,
    input  logic        i_wr_ctrl,
    input  logic [7:0]  i_wr_data,
    input  logic [15:0] i_drp_rdata,
    input  logic        i_drp_done,
    input  logic        i_rx_rstdone,
    output logic        o_drp_en,
    output logic        o_drp_we,
    output logic [8:0]  o_drp_addr,
    output logic [15:0] o_drp_wdata,
    output logic [15:0] o_wd,
    output logic [15:0] o_ad,
    output logic [15:0] o_rd,
    output logic [7:0]  o_stat
);

    // Last in-flight count value; the op aborts on the edge that would reach TIMEOUT
    localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT - 1);

    drp_lane_state_t r_state;
    logic [15:0]     r_wd;
    logic [7:0]      r_ad_lo;
    logic            r_ad_we;
    logic            r_ad_a8;
    logic [15:0]     r_rd;
    logic [15:0]     r_cnt;
    logic            r_ovr;
    logic            r_tmo;
    logic            r_drp_en;
    logic            r_drp_we;
    logic [8:0]      r_drp_addr;
    logic [15:0]     r_drp_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= DRP_IDLE;
            r_wd        <= 16'h0000;
            r_ad_lo     <= 8'h00;
            r_ad_we     <= 1'b0;
            r_ad_a8     <= 1'b0;
            r_rd        <= 16'h0000;
            r_cnt       <= 16'h0000;
            r_ovr       <= 1'b0;
            r_tmo       <= 1'b0;
            r_drp_en    <= 1'b0;
            r_drp_we    <= 1'b0;
            r_drp_addr  <= 9'h000;
            r_drp_wdata <= 16'h0000;
        end else begin
            r_drp_en <= 1'b0;

            // WD/AD lo staging is always writable, even while an op is in flight;
            // the DRP outputs only reload at launch so they remain stable.
            if (i_wr_wd_lo) r_wd[7:0]  <= i_wr_data;
            if (i_wr_wd_hi) r_wd[15:8] <= i_wr_data;
            if (i_wr_ad_lo) r_ad_lo    <= i_wr_data;

            // Clear first so that any flag-set below in the same cycle wins
            if (i_wr_ctrl && i_wr_data[0]) begin
                r_ovr <= 1'b0;
                r_tmo <= 1'b0;
            end

            case (r_state)
                DRP_IDLE: begin
                    if (i_wr_ad_hi) begin
                        r_ad_we     <= i_wr_data[7];
                        r_ad_a8     <= i_wr_data[0];
                        r_drp_en    <= 1'b1;
                        r_drp_we    <= i_wr_data[7];
                        r_drp_addr  <= {i_wr_data[0], r_ad_lo};
                        r_drp_wdata <= r_wd;
                        r_cnt       <= 16'h0000;
                        r_state     <= DRP_BUSY;
                    end
                end
                DRP_BUSY: begin
                    if (i_wr_ad_hi) r_ovr <= 1'b1;
                    // Completion takes priority over a coincident timeout
                    if (i_drp_done) begin
                        if (!r_drp_we) r_rd <= i_drp_rdata;
                        r_state <= DRP_IDLE;
                    end else if (r_cnt == c_TMO_LAST) begin
                        r_rd    <= 16'hFFFF;
                        r_tmo   <= 1'b1;
                        r_state <= DRP_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'h0001;
                    end
                end
                default: r_state <= DRP_IDLE;
            endcase
        end
    end

    assign o_drp_en    = r_drp_en;
    assign o_drp_we    = r_drp_we;
    assign o_drp_addr  = r_drp_addr;
    assign o_drp_wdata = r_drp_wdata;
    assign o_wd        = r_wd;
    assign o_ad        = {r_ad_we, 6'b000000, r_ad_a8, r_ad_lo};
    assign o_rd        = r_rd;
    assign o_stat      = {4'b0000, r_ovr, r_tmo, i_rx_rstdone, (r_state == DRP_BUSY)};

endmodule
`default_nettype wire

// File: rtl/mgmt_drp_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mgmt_drp_bridge
// Description : Maps NUM_LANES SERDES DRP ports into the 16-bit address /
//               8-bit data management register space. Decodes lane windows,
//               fans write strobes out to per-lane controllers and returns
//               read data through a registered mux (1-cycle latency).
//               Ports:
//                 clk, rst                 - clock, sync active-high reset
//                 rd_en/rd_addr            - read request
//                 rd_valid/rd_data         - registered read response
//                 wr_en/wr_addr/wr_data    - register write
//                 drp_en/we/addr/wdata     - per-lane DRP requests (packed)
//                 drp_rdata/drp_done       - per-lane DRP responses (packed)
//                 rx_rstdone               - per-lane status input
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module mgmt_drp_bridge
    import DRPBridgePkg::*;
#(
    parameter int          NUM_LANES   = 4,
    parameter logic [15:0] BASE_ADDR   = 16'h0080,
    parameter logic [15:0] LANE_STRIDE = 16'h0020,
    parameter int          TIMEOUT     = 1023
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd_en,
    input  logic [15:0]             rd_addr,
    output logic                    rd_valid,
    output logic [7:0]              rd_data,
    input  logic                    wr_en,
    input  logic [15:0]             wr_addr,
    input  logic [7:0]              wr_data,
    output logic [NUM_LANES-1:0]    drp_en,
    output logic [NUM_LANES-1:0]    drp_we,
    output logic [9*NUM_LANES-1:0]  drp_addr,
    output logic [16*NUM_LANES-1:0] drp_wdata,
    input  logic [16*NUM_LANES-1:0] drp_rdata,
    input  logic [NUM_LANES-1:0]    drp_done,
    input  logic [NUM_LANES-1:0]    rx_rstdone
);

    localparam int          c_STRIDE_SH = $clog2(LANE_STRIDE);
    localparam logic [15:0] c_NUM_LANES = 16'(NUM_LANES);

    // ---------------- address decode ----------------
    logic [15:0] w_rd_lane;
    logic [15:0] w_wr_lane;
    logic [3:0]  w_rd_off;
    logic [3:0]  w_wr_off;
    logic        w_rd_hit;
    logic        w_wr_hit;

    assign w_rd_lane = (rd_addr - BASE_ADDR) >> c_STRIDE_SH;
    assign w_wr_lane = (wr_addr - BASE_ADDR) >> c_STRIDE_SH;
    assign w_rd_off  = rd_addr[3:0];
    assign w_wr_off  = wr_addr[3:0];
    // The >= BASE_ADDR test rejects addresses whose subtraction wrapped
    assign w_rd_hit  = (rd_addr >= BASE_ADDR) && (w_rd_lane < c_NUM_LANES) && drp_off_readable(w_rd_off);
    assign w_wr_hit  = wr_en && (wr_addr >= BASE_ADDR) && (w_wr_lane < c_NUM_LANES)
                       && drp_off_writable(w_wr_off);

    // ---------------- lane instances ----------------
    logic [15:0] w_wd   [NUM_LANES];
    logic [15:0] w_ad   [NUM_LANES];
    logic [15:0] w_rd   [NUM_LANES];
    logic [7:0]  w_stat [NUM_LANES];

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic w_sel;
        assign w_sel = w_wr_hit && (w_wr_lane == 16'(i));

        drp_lane_ctl #(
            .TIMEOUT (TIMEOUT)
        ) u_lane (
            .clk          (clk),
            .rst          (rst),
            .i_wr_wd_lo   (w_sel && (w_wr_off == DRP_REG_WD)),
            .i_wr_wd_hi   (w_sel && (w_wr_off == DRP_REG_WD_1)),
            .i_wr_ad_lo   (w_sel && (w_wr_off == DRP_REG_AD)),
            .i_wr_ad_hi   (w_sel && (w_wr_off == DRP_REG_AD_1)),
            .i_wr_ctrl    (w_sel && (w_wr_off == DRP_REG_CTRL)),
            .i_wr_data    (wr_data),
            .i_drp_rdata  (drp_rdata[16*i +: 16]),
            .i_drp_done   (drp_done[i]),
            .i_rx_rstdone (rx_rstdone[i]),
            .o_drp_en     (drp_en[i]),
            .o_drp_we     (drp_we[i]),
            .o_drp_addr   (drp_addr[9*i +: 9]),
            .o_drp_wdata  (drp_wdata[16*i +: 16]),
            .o_wd         (w_wd[i]),
            .o_ad         (w_ad[i]),
            .o_rd         (w_rd[i]),
            .o_stat       (w_stat[i])
        );
    end

    // ---------------- read mux ----------------
    logic [7:0] w_rd_byte;

    always_comb begin
        w_rd_byte = 8'h00;
        if (w_rd_hit) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (w_rd_lane == 16'(i)) begin
                    case (w_rd_off)
                        DRP_REG_WD:   w_rd_byte = w_wd[i][7:0];
                        DRP_REG_WD_1: w_rd_byte = w_wd[i][15:8];
                        DRP_REG_AD:   w_rd_byte = w_ad[i][7:0];
                        DRP_REG_AD_1: w_rd_byte = w_ad[i][15:8];
                        DRP_REG_RD:   w_rd_byte = w_rd[i][7:0];
                        DRP_REG_RD_1: w_rd_byte = w_rd[i][15:8];
                        DRP_REG_STAT: w_rd_byte = w_stat[i];
                        default:      w_rd_byte = 8'h00;
                    endcase
                end
            end
        end
    end

    logic       r_rd_valid;
    logic [7:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= 8'h00;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) r_rd_data <= w_rd_byte;
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_mgmt_drp_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_mgmt_drp_bridge
// Description : Directed self-checking bench for mgmt_drp_bridge with the
//               default parameters (4 lanes, base 0x0080, stride 0x20,
//               timeout 1023). Lane windows: 0x80, 0xA0, 0xC0, 0xE0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mgmt_drp_bridge;

    localparam int NL = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           rd_en;
    logic [15:0]    rd_addr;
    logic           rd_valid;
    logic [7:0]     rd_data;
    logic           wr_en;
    logic [15:0]    wr_addr;
    logic [7:0]     wr_data;
    logic [NL-1:0]  drp_en;
    logic [NL-1:0]  drp_we;
    logic [9*NL-1:0]  drp_addr;
    logic [16*NL-1:0] drp_wdata;
    logic [16*NL-1:0] drp_rdata;
    logic [NL-1:0]  drp_done;
    logic [NL-1:0]  rx_rstdone;

    int n_cmp = 0;
    int n_err = 0;
    int unsigned edges = 0;
    int unsigned e0;

    mgmt_drp_bridge #(
        .NUM_LANES   (4),
        .BASE_ADDR   (16'h0080),
        .LANE_STRIDE (16'h0020),
        .TIMEOUT     (1023)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .drp_en     (drp_en),
        .drp_we     (drp_we),
        .drp_addr   (drp_addr),
        .drp_wdata  (drp_wdata),
        .drp_rdata  (drp_rdata),
        .drp_done   (drp_done),
        .rx_rstdone (rx_rstdone)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic rdchk(input string tag, input logic [15:0] a, input logic [7:0] exp);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en   = 1'b0;
        chk({tag, "_valid"}, {15'd0, rd_valid}, 16'h0001);
        chk(tag, {8'h00, rd_data}, {8'h00, exp});
    endtask

    task automatic done_pulse(input logic [NL-1:0] m, input logic [16*NL-1:0] rdat);
        drp_rdata = rdat;
        drp_done  = m;
        tick();
        drp_done  = '0;
    endtask

    initial begin
        rst        = 1'b1;
        rd_en      = 1'b0;
        rd_addr    = 16'h0000;
        wr_en      = 1'b0;
        wr_addr    = 16'h0000;
        wr_data    = 8'h00;
        drp_rdata  = '0;
        drp_done   = '0;
        rx_rstdone = 4'b0101;
        repeat (3) tick();

        // ---- reset state ----
        chk("rst_rd_valid", {15'd0, rd_valid}, 16'h0000);
        chk("rst_rd_data", {8'h00, rd_data}, 16'h0000);
        chk("rst_drp_en", {12'd0, drp_en}, 16'h0000);
        chk("rst_drp_we", {12'd0, drp_we}, 16'h0000);
        chk("rst_drp_addr_l3", {7'd0, drp_addr[27 +: 9]}, 16'h0000);
        chk("rst_drp_wdata_l1", drp_wdata[16 +: 16], 16'h0000);
        rst = 1'b0;
        tick();
        rdchk("rst_stat_l0", 16'h008A, 8'h02);
        rdchk("rst_stat_l1", 16'h00AA, 8'h00);
        rdchk("rst_rd_l0", 16'h0088, 8'h00);
        tick();
        chk("rd_valid_drop", {15'd0, rd_valid}, 16'h0000);

        // ---- test 1: lane 2 DRP read ----
        wr(16'h00C6, 8'h34);
        wr(16'h00C7, 8'h01);
        chk("t1_drp_en", {12'd0, drp_en}, 16'h0004);
        chk("t1_drp_addr", {7'd0, drp_addr[18 +: 9]}, 16'h0134);
        chk("t1_drp_we", {15'd0, drp_we[2]}, 16'h0000);
        rdchk("t1_stat_busy", 16'h00CA, 8'h03);
        chk("t1_drp_en_pulse", {12'd0, drp_en}, 16'h0000);
        repeat (3) tick();
        done_pulse(4'b0100, {16'h0, 16'hBEEF, 16'h0, 16'h0});
        rdchk("t1_stat_idle", 16'h00CA, 8'h02);
        rdchk("t1_rd_lo", 16'h00C8, 8'hEF);
        rdchk("t1_rd_hi", 16'h00C9, 8'hBE);

        // ---- test 2: lane 0 DRP write ----
        wr(16'h0084, 8'h5A);
        wr(16'h0085, 8'hA5);
        wr(16'h0087, 8'h80);
        chk("t2_drp_en", {12'd0, drp_en}, 16'h0001);
        chk("t2_drp_we", {15'd0, drp_we[0]}, 16'h0001);
        chk("t2_drp_wdata", drp_wdata[0 +: 16], 16'hA55A);
        chk("t2_drp_addr", {7'd0, drp_addr[0 +: 9]}, 16'h0000);
        done_pulse(4'b0001, {16'h0, 16'h0, 16'h0, 16'h1234});
        rdchk("t2_rd_lo", 16'h0088, 8'h00);
        rdchk("t2_rd_hi", 16'h0089, 8'h00);
        rdchk("t2_stat", 16'h008A, 8'h02);
        rdchk("t2_wd_lo_rb", 16'h0084, 8'h5A);
        rdchk("t2_ad_hi_rb", 16'h0087, 8'h80);

        // ---- test 3: lane 1 timeout ----
        wr(16'h00A6, 8'h11);
        wr(16'h00A7, 8'h00);
        e0 = edges;
        chk("t3_drp_en", {12'd0, drp_en}, 16'h0002);
        while (edges - e0 < 1021) tick();
        rdchk("t3_busy_m2", 16'h00AA, 8'h01);  // cycle 1021 after drp_en
        rdchk("t3_busy_m1", 16'h00AA, 8'h01);  // cycle 1022, last busy cycle
        rdchk("t3_stat_tmo", 16'h00AA, 8'h04); // cycle 1023, idle
        rdchk("t3_rd_lo", 16'h00A8, 8'hFF);
        rdchk("t3_rd_hi", 16'h00A9, 8'hFF);
        done_pulse(4'b0010, {16'h0, 16'h0, 16'h5555, 16'h0});
        rdchk("t3_late_done", 16'h00A8, 8'hFF);
        rdchk("t3_stat_keep", 16'h00AA, 8'h04);
        wr(16'h00AB, 8'h01);
        rdchk("t3_stat_clr", 16'h00AA, 8'h00);

        // ---- test 4: lane 3 overrun, done coincident with timeout ----
        wr(16'h00E6, 8'h02);
        wr(16'h00E7, 8'h01);
        e0 = edges;
        chk("t4_drp_en", {12'd0, drp_en}, 16'h0008);
        chk("t4_drp_addr", {7'd0, drp_addr[27 +: 9]}, 16'h0102);
        wr(16'h00E7, 8'h80);
        chk("t4_no_relaunch", {12'd0, drp_en}, 16'h0000);
        chk("t4_we_stable", {15'd0, drp_we[3]}, 16'h0000);
        rdchk("t4_adhi_kept", 16'h00E7, 8'h01);
        rdchk("t4_stat_ovr", 16'h00EA, 8'h09);
        wr(16'h00E6, 8'h55);
        chk("t4_addr_stable", {7'd0, drp_addr[27 +: 9]}, 16'h0102);
        rdchk("t4_adlo_staged", 16'h00E6, 8'h55);
        while (edges - e0 < 1022) tick();
        done_pulse(4'b1000, {16'hCAFE, 16'h0, 16'h0, 16'h0});
        rdchk("t4_stat_done_wins", 16'h00EA, 8'h08);
        rdchk("t4_rd_lo", 16'h00E8, 8'hFE);
        rdchk("t4_rd_hi", 16'h00E9, 8'hCA);

        // ---- concurrent completions on lanes 1 and 2 ----
        wr(16'h00A7, 8'h00);
        wr(16'h00C7, 8'h00);
        done_pulse(4'b0110, {16'h0, 16'h2222, 16'h1111, 16'h0});
        rdchk("cc_l1_rd", 16'h00A8, 8'h11);
        rdchk("cc_l2_rd", 16'h00C9, 8'h22);
        wr(16'h00C8, 8'h77);
        rdchk("ro_write_ignored", 16'h00C8, 8'h22);
        rdchk("ctrl_reads_zero", 16'h008B, 8'h00);
        rdchk("below_base", 16'h0074, 8'h00);

        // ---- test 5: lanes 0 and 3 busy, reset mid-op ----
        wr(16'h0087, 8'h00);
        chk("t5_l0_en", {12'd0, drp_en}, 16'h0001);
        wr(16'h00E7, 8'h00);
        chk("t5_l3_en", {12'd0, drp_en}, 16'h0008);
        rdchk("t5_l0_busy", 16'h008A, 8'h03);
        rdchk("t5_l3_busy", 16'h00EA, 8'h09);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (2) tick();
        chk("t5_no_drp_en", {12'd0, drp_en}, 16'h0000);
        rdchk("t5_l0_stat", 16'h008A, 8'h02);
        rdchk("t5_l3_stat", 16'h00EA, 8'h00);
        rdchk("t5_l3_rd", 16'h00E8, 8'h00);
        done_pulse(4'b0001, {16'h0, 16'h0, 16'h0, 16'h9999});
        rdchk("t5_idle_done", 16'h0088, 8'h00);
        rdchk("t5_lane8_oob", 16'h0180, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
